// File: rtl/wave_detector.sv
// wave_detector -- coherent I/Q detector for one S-parameter wave (a1, b1 or b2).
//
// ADC samples are mixed with a fixed fs/4 quadrature reference (+1, -j, -1, +j)
// and summed over a block of 2^LOG2N accepted samples. The I/Q sums are offered
// on a valid/ready output and held until the consumer takes them.
//
// Optional feature macro: WAVE_DET_MAG_EN
//   When defined, adds output mag = max(|I|,|Q|) + min(|I|,|Q|)/2, computed in
//   an extra MAG state one cycle after the sums are latched.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      pulse that begins a block when idle
//   abort      drops the block in progress (ACCUM/MAG) and returns to idle
//   s_data     signed ADC sample, DW bits
//   s_valid    sample present
//   s_ready    detector accepts samples (ACCUM only)
//   busy       block in progress or result pending
//   i_sum      signed in-phase sum, AW bits
//   q_sum      signed quadrature sum, AW bits
//   mag        unsigned magnitude estimate, AW bits (WAVE_DET_MAG_EN only)
//   out_valid  result present
//   out_ready  consumer accepts result
module wave_detector #(
  parameter int DW    = 12,
  parameter int LOG2N = 8,
  localparam int AW   = DW + LOG2N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 busy,
  output logic signed [AW-1:0] i_sum,
  output logic signed [AW-1:0] q_sum,
`ifdef WAVE_DET_MAG_EN
  output logic        [AW-1:0] mag,
`endif
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
`ifdef WAVE_DET_MAG_EN
    , MAG = 2'd3
`endif
  } state_t;

  state_t state, state_nxt;

  logic                 blk_start;
  logic                 fire;
  logic                 last;
  logic [LOG2N-1:0]     cnt_p0;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] acc_i_p0, acc_q_p0;
  logic signed [AW-1:0] acc_i_nxt, acc_q_nxt;

`ifdef WAVE_DET_MAG_EN
  function automatic logic [AW-1:0] abs_val(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] neg;
    neg = -v;
    return v[AW-1] ? $unsigned(neg) : $unsigned(v);
  endfunction

  // Alpha-max-plus-beta-min with alpha=1, beta=1/2.
  function automatic logic [AW-1:0] mag_est(input logic signed [AW-1:0] i_v,
                                            input logic signed [AW-1:0] q_v);
    logic [AW-1:0] a, b;
    a = abs_val(i_v);
    b = abs_val(q_v);
    return (a > b) ? a + (b >> 1) : b + (a >> 1);
  endfunction
`endif

  // Abort takes priority over start and over a simultaneous sample.
  assign blk_start = (state == IDLE) && start && !abort;
  assign fire      = (state == ACCUM) && s_valid && !abort;
  assign last      = &cnt_p0;
  assign x_ext     = AW'(s_data);

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (blk_start) state_nxt = ACCUM;
      ACCUM: begin
        if (abort) state_nxt = IDLE;
`ifdef WAVE_DET_MAG_EN
        else if (fire && last) state_nxt = MAG;
`else
        else if (fire && last) state_nxt = DONE;
`endif
      end
`ifdef WAVE_DET_MAG_EN
      MAG:   state_nxt = abort ? IDLE : DONE;
`endif
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    s_ready   = (state == ACCUM);
    out_valid = (state == DONE);
`ifdef WAVE_DET_MAG_EN
    busy      = (state == ACCUM) || (state == MAG) || (state == DONE);
`else
    busy      = (state == ACCUM) || (state == DONE);
`endif
  end

  // ---- Stage p0: fs/4 mixing and accumulation ----
  always_comb begin
    acc_i_nxt = acc_i_p0;
    acc_q_nxt = acc_q_p0;
    unique case (cnt_p0[1:0])
      2'd0:    acc_i_nxt = acc_i_p0 + x_ext;
      2'd1:    acc_q_nxt = acc_q_p0 - x_ext;
      2'd2:    acc_i_nxt = acc_i_p0 - x_ext;
      default: acc_q_nxt = acc_q_p0 + x_ext;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt_p0 <= '0;
    else if (blk_start) cnt_p0 <= '0;
    else if (fire)      cnt_p0 <= cnt_p0 + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (blk_start) begin
      acc_i_p0 <= '0;
      acc_q_p0 <= '0;
    end else if (fire) begin
      acc_i_p0 <= acc_i_nxt;
      acc_q_p0 <= acc_q_nxt;
    end
  end

  // ---- Stage p1: result registers, written only on the block's last sample ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_sum <= '0;
      q_sum <= '0;
    end else if (fire && last) begin
      i_sum <= acc_i_nxt;
      q_sum <= acc_q_nxt;
    end
  end

`ifdef WAVE_DET_MAG_EN
  // ---- Stage p2: magnitude estimate from the latched sums ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              mag <= '0;
    else if (state == MAG)   mag <= mag_est(i_sum, q_sum);
  end
`endif

endmodule
